mod_counter_seq: RTL and testbench

- Sequencer that owns a programmable modulo counter and runs it for a configured number of wrap periods, or continuously.
- Sits between the control/config logic and any consumer of the count. Those consumers include baud/tick generators and frame timers.
- Provides start/stop/hold control, wrap and done event pulses, busy status, and the live count with its complement.

---
 rtl/mod_counter_seq.sv | 136 +++++++++++++
 tb/tb_mod_counter_seq.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/mod_counter_seq.sv
// Start/stop/hold sequencer around a programmable modulo counter that runs for a
// configured number of wrap periods, or continuously.
module mod_counter_seq #(
    parameter int unsigned NBITS        = 4,
    parameter int unsigned RBITS        = 4,
    parameter int unsigned DEFAULT_UPTO = 11
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic             start,
    input  logic             stop,
    input  logic             hold,
    input  logic [NBITS-1:0] cfg_upto,
    input  logic [RBITS-1:0] cfg_reps,
    input  logic             cfg_cont,
    output logic [NBITS-1:0] q,
    output logic [NBITS-1:0] qbar,
    output logic             wrap,
    output logic             done,
    output logic             busy,
    output logic [1:0]       state,
    output logic [RBITS-1:0] reps_left
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    localparam logic [NBITS-1:0] CNT_ONE  = NBITS'(1);
    localparam logic [RBITS-1:0] REPS_ONE = RBITS'(1);

    state_t           state_q, state_d;
    logic [NBITS-1:0] cnt_q, cnt_d;
    logic [NBITS-1:0] upto_q, upto_d;
    logic [RBITS-1:0] reps_q, reps_d;
    logic             cont_q, cont_d;
    logic             wrap_q, wrap_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic             at_last;

    // upto=0 yields an all-ones terminal value, giving the full 2^NBITS period.
    assign at_last = (cnt_q == (upto_q - CNT_ONE));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        upto_d  = upto_q;
        reps_d  = reps_q;
        cont_d  = cont_q;
        wrap_d  = 1'b0;
        done_d  = 1'b0;
        busy_d  = busy_q;
        case (state_q)
            ST_RUN: begin
                if (stop) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    reps_d  = '0;
                    busy_d  = 1'b0;
                end else if (hold) begin
                    state_d = ST_HOLD;
                end else if (at_last) begin
                    cnt_d  = '0;
                    wrap_d = 1'b1;
                    if (!cont_q) begin
                        reps_d = reps_q - REPS_ONE;
                        if (reps_q <= REPS_ONE) begin
                            done_d  = 1'b1;
                            state_d = ST_IDLE;
                            busy_d  = 1'b0;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_HOLD: begin
                if (stop) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    reps_d  = '0;
                    busy_d  = 1'b0;
                end else if (!hold) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                // The unused encoding falls back to IDLE here.
                state_d = ST_IDLE;
                cnt_d   = '0;
                busy_d  = 1'b0;
                if (start && !stop) begin
                    state_d = ST_RUN;
                    busy_d  = 1'b1;
                    upto_d  = cfg_upto;
                    cont_d  = cfg_cont;
                    reps_d  = (cfg_reps == '0) ? REPS_ONE : cfg_reps;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            upto_q  <= NBITS'(DEFAULT_UPTO);
            reps_q  <= '0;
            cont_q  <= 1'b0;
            wrap_q  <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            upto_q  <= upto_d;
            reps_q  <= reps_d;
            cont_q  <= cont_d;
            wrap_q  <= wrap_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign q         = cnt_q;
    assign qbar      = ~cnt_q;
    assign wrap      = wrap_q;
    assign done      = done_q;
    assign busy      = busy_q;
    assign state     = state_q;
    assign reps_left = reps_q;

endmodule

// File: tb/tb_mod_counter_seq.sv
// Directed and randomized bench for mod_counter_seq against a cycle-level
// behavioural model built from the counting rules.
module tb_mod_counter_seq;

    logic       clk = 1'b0;
    logic       clear_n;
    logic       start, stop, hold, cfg_cont;
    logic [3:0] cfg_upto, cfg_reps;
    logic [3:0] q, qbar, reps_left;
    logic       wrap, done, busy;
    logic [1:0] state;

    int checks   = 0;
    int failures = 0;

    // behavioural model: 0=idle 1=run 2=hold
    int m_state, m_q, m_reps, m_period, m_cont, m_wrap, m_done;

    mod_counter_seq #(.NBITS(4), .RBITS(4), .DEFAULT_UPTO(11)) dut (
        .clk       (clk),
        .clear_n   (clear_n),
        .start     (start),
        .stop      (stop),
        .hold      (hold),
        .cfg_upto  (cfg_upto),
        .cfg_reps  (cfg_reps),
        .cfg_cont  (cfg_cont),
        .q         (q),
        .qbar      (qbar),
        .wrap      (wrap),
        .done      (done),
        .busy      (busy),
        .state     (state),
        .reps_left (reps_left)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_q = 0; m_reps = 0; m_period = 11; m_cont = 0;
        m_wrap = 0; m_done = 0;
    endtask

    task automatic model_edge();
        if (!clear_n) begin
            model_reset();
        end else begin
            m_wrap = 0;
            m_done = 0;
            if (m_state == 1 || m_state == 2) begin
                if (stop) begin
                    m_state = 0; m_q = 0; m_reps = 0;
                end else if (m_state == 2) begin
                    if (!hold) m_state = 1;
                end else if (hold) begin
                    m_state = 2;
                end else if (m_q + 1 == m_period) begin
                    m_q = 0;
                    m_wrap = 1;
                    if (m_cont == 0) begin
                        m_reps = m_reps - 1;
                        if (m_reps == 0) begin
                            m_done = 1;
                            m_state = 0;
                        end
                    end
                end else begin
                    m_q = m_q + 1;
                end
            end else begin
                m_q = 0;
                if (start && !stop) begin
                    m_period = (cfg_upto == 0) ? 16 : int'(cfg_upto);
                    m_cont   = int'(cfg_cont);
                    m_reps   = (cfg_reps == 0) ? 1 : int'(cfg_reps);
                    m_state  = 1;
                end
            end
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".q"},         q,         m_q);
        check({tag, ".qbar"},      qbar,      (~m_q) & 15);
        check({tag, ".wrap"},      wrap,      m_wrap);
        check({tag, ".done"},      done,      m_done);
        check({tag, ".busy"},      busy,      (m_state != 0) ? 1 : 0);
        check({tag, ".state"},     state,     m_state);
        check({tag, ".reps_left"}, reps_left, m_reps);
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        compare_all(tag);
    endtask

    task automatic idle_inputs();
        start = 0; stop = 0; hold = 0;
    endtask

    task automatic launch(input int upto, input int reps, input int cont, input string tag);
        cfg_upto = 4'(upto); cfg_reps = 4'(reps); cfg_cont = cont[0];
        start = 1;
        step(tag);
        start = 0;
    endtask

    initial begin
        int wraps, dones;
        clear_n = 0;
        idle_inputs();
        cfg_upto = 0; cfg_reps = 0; cfg_cont = 0;
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        compare_all("reset");
        #2 clear_n = 1;

        // finite run: upto=11, reps=2, with a retrigger attempt and a config change mid-run
        launch(11, 2, 0, "t1_start");
        check("t1_reps_latched", reps_left, 2);
        wraps = 0; dones = 0;
        for (int i = 0; i < 26; i++) begin
            if (i == 4) begin cfg_upto = 3; start = 1; end
            if (i == 5) start = 0;
            step("t1");
            wraps += int'(wrap);
            dones += int'(done);
            if (i == 10) check("t1_first_wrap", {wrap, reps_left}, {1'b1, 4'd1});
            if (i == 21) check("t1_second_wrap_done", {wrap, done, busy}, 3'b110);
        end
        check("t1_wrap_count", wraps, 2);
        check("t1_done_count", dones, 1);

        // continuous run, upto=4, stopped after 10 counts
        launch(4, 5, 1, "t2_start");
        for (int i = 0; i < 10; i++) step("t2");
        check("t2_q_before_stop", q, 2);
        stop = 1;
        step("t2_stop");
        stop = 0;
        check("t2_stopped", {state, q, done, wrap}, {2'd0, 4'd0, 1'b0, 1'b0});
        step("t2_after");

        // hold for 3 cycles at q=5, upto=8
        launch(8, 1, 0, "t3_start");
        for (int i = 0; i < 20 && q != 5; i++) step("t3_run");
        check("t3_reached5", q, 5);
        hold = 1;
        for (int i = 0; i < 3; i++) begin
            step("t3_hold");
            check("t3_hold_state", {state, q}, {2'd2, 4'd5});
        end
        hold = 0;
        step("t3_release");
        step("t3_resume");
        check("t3_resumed6", q, 6);
        for (int i = 0; i < 4; i++) step("t3_tail");

        // upto=0 and reps=0: one full 16-count period
        launch(0, 0, 0, "t4_start");
        for (int i = 0; i < 16; i++) step("t4");
        check("t4_done", {wrap, done, state}, {1'b1, 1'b1, 2'd0});
        step("t4_after");

        // start and stop together while idle
        start = 1; stop = 1;
        step("t5_start_stop");
        idle_inputs();
        check("t5_idle", state, 0);

        // upto=1: q stuck at 0, wrap every run cycle
        launch(1, 3, 0, "t6_start");
        for (int i = 0; i < 4; i++) step("t6");

        // randomized control and configuration
        for (int i = 0; i < 400; i++) begin
            start    = ($urandom_range(0, 3) == 0);
            stop     = ($urandom_range(0, 15) == 0);
            hold     = ($urandom_range(0, 7) == 0);
            cfg_upto = 4'($urandom_range(0, 15));
            cfg_reps = 4'($urandom_range(0, 3));
            cfg_cont = ($urandom_range(0, 5) == 0);
            step("rand");
        end
        idle_inputs();
        stop = 1;
        step("rand_stop");
        stop = 0;

        // asynchronous reset between edges at q=7
        launch(11, 2, 0, "t7_start");
        for (int i = 0; i < 20 && q != 7; i++) step("t7_run");
        check("t7_reached7", q, 7);
        #2 clear_n = 0;
        #1;
        model_reset();
        compare_all("t7_async");
        step("t7_in_reset");
        #2 clear_n = 1;
        for (int i = 0; i < 15; i++) step("t7_after");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
